// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel and KxK window types plus the window generator state enum.
package cnn_pkg;
   localparam int INPUT_WIDTH = 8;
   localparam int K           = 3;
   localparam int WIN_SIZE    = K * K;

   typedef logic signed [INPUT_WIDTH-1:0] pix_t;
   typedef pix_t [WIN_SIZE-1:0] win_t;

   typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} win_state_t;
endpackage

// File: rtl/ifm_window_gen_if.sv
// Pixel-in / window-out handshake bundle of the IFM window generator.
// Optional macro IFM_WIN_CNT_EN adds the win_count status output.
interface ifm_window_gen_if;
   import cnn_pkg::*;

   logic frame_start;
   logic pix_valid;
   logic pix_ready;
   pix_t pix_data;
   logic win_stall;
   logic ready_load;
   win_t ifm_window;
   logic frame_done;
`ifdef IFM_WIN_CNT_EN
   logic [15:0] win_count;

   modport master (
      input  frame_start, pix_valid, pix_data, win_stall,
      output pix_ready, ready_load, ifm_window, frame_done, win_count
   );
   modport slave (
      output frame_start, pix_valid, pix_data, win_stall,
      input  pix_ready, ready_load, ifm_window, frame_done, win_count
   );
`else
   modport master (
      input  frame_start, pix_valid, pix_data, win_stall,
      output pix_ready, ready_load, ifm_window, frame_done
   );
   modport slave (
      output frame_start, pix_valid, pix_data, win_stall,
      input  pix_ready, ready_load, ifm_window, frame_done
   );
`endif
endinterface

// File: rtl/ifm_line_buffer.sv
// One image row of pixel delay: dout is the pixel written DEPTH shifts ago.
// Storage is a circular array; contents are intentionally not reset.
module ifm_line_buffer
   import cnn_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic shift_en,
   input  pix_t din,
   output pix_t dout
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   pix_t          mem [DEPTH];
   logic [AW-1:0] ptr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (shift_en) begin
         ptr_reg <= (ptr_reg == AW'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (shift_en) begin
         mem[ptr_reg] <= din;
      end
   end

   // The slot about to be overwritten holds the pixel from exactly one row earlier.
   assign dout = mem[ptr_reg];
endmodule

// File: rtl/ifm_window_gen.sv
// Raster pixel stream to KxK sliding windows (stride 1, no padding) for the PE array.
// Optional macro IFM_WIN_CNT_EN adds a saturating count of consumed windows.
module ifm_window_gen
   import cnn_pkg::*;
#(
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32
) (
   input logic            clk,
   input logic            rst,
   ifm_window_gen_if.master bus
);
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);

   win_state_t       state_reg;
   logic [COL_W-1:0] col_reg;
   logic [ROW_W-1:0] row_reg;
   logic             last_seen_reg;
   logic             ready_load_reg;
   logic             frame_done_reg;
   pix_t             win_reg [K][K];

   pix_t tap    [K-1];
   pix_t col_in [K];
   logic busy;
   logic pix_ready_int;
   logic accept;
   logic consume;
   logic at_last_col;
   logic at_last_row;
   logic win_pos;

   assign busy          = (state_reg == FILL) || (state_reg == STREAM);
   assign consume       = ready_load_reg && !bus.win_stall;
   // last_seen_reg blocks pixels of the next plane until this plane has closed.
   assign pix_ready_int = busy && !last_seen_reg && !(ready_load_reg && bus.win_stall);
   assign accept        = bus.pix_valid && pix_ready_int;
   assign at_last_col   = (col_reg == COL_W'(IMG_WIDTH - 1));
   assign at_last_row   = (row_reg == ROW_W'(IMG_HEIGHT - 1));
   assign win_pos       = (row_reg >= ROW_W'(K - 1)) && (col_reg >= COL_W'(K - 1));

   generate
      for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
         pix_t lb_din;
         if (gi == 0) begin : g_head
            assign lb_din = bus.pix_data;
         end else begin : g_chain
            assign lb_din = tap[gi-1];
         end
         ifm_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb (
            .clk      (clk),
            .rst      (rst),
            .shift_en (accept),
            .din      (lb_din),
            .dout     (tap[gi])
         );
      end

      // Bottom window row takes the live pixel; row r above it takes a tap K-1-r rows old.
      for (genvar gi = 0; gi < K; gi++) begin : g_col_in
         if (gi == K - 1) begin : g_live
            assign col_in[gi] = bus.pix_data;
         end else begin : g_tap
            assign col_in[gi] = tap[K-2-gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_reg[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_reg[r][c] <= win_reg[r][c+1];
            end
            win_reg[r][K-1] <= col_in[r];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         row_reg        <= '0;
         col_reg        <= '0;
         last_seen_reg  <= 1'b0;
         ready_load_reg <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= 1'b0;
         if (accept && win_pos) begin
            ready_load_reg <= 1'b1;
         end else if (consume) begin
            ready_load_reg <= 1'b0;
         end
         case (state_reg)
            IDLE: begin
               if (bus.frame_start) begin
                  state_reg     <= FILL;
                  row_reg       <= '0;
                  col_reg       <= '0;
                  last_seen_reg <= 1'b0;
               end
            end
            FILL, STREAM: begin
               if (accept) begin
                  if (at_last_col) begin
                     col_reg <= '0;
                     row_reg <= row_reg + 1'b1;
                  end else begin
                     col_reg <= col_reg + 1'b1;
                  end
                  if (win_pos) begin
                     state_reg <= STREAM;
                  end
                  if (at_last_col && at_last_row) begin
                     last_seen_reg <= 1'b1;
                  end
               end
               if (last_seen_reg && consume) begin
                  state_reg      <= DONE;
                  frame_done_reg <= 1'b1;
               end
            end
            DONE: begin
               state_reg     <= IDLE;
               last_seen_reg <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.ifm_window = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            bus.ifm_window[r*K+c] = win_reg[r][c];
         end
      end
   end

   assign bus.pix_ready  = pix_ready_int;
   assign bus.ready_load = ready_load_reg;
   assign bus.frame_done = frame_done_reg;

`ifdef IFM_WIN_CNT_EN
   logic [15:0] win_count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_count_reg <= '0;
      end else if (state_reg == IDLE && bus.frame_start) begin
         win_count_reg <= '0;
      end else if (consume && win_count_reg != 16'hFFFF) begin
         win_count_reg <= win_count_reg + 16'd1;
      end
   end

   assign bus.win_count = win_count_reg;
`endif
endmodule

// File: tb/tb_ifm_window_gen.sv
// Bench for ifm_window_gen: 5x5 directed table plus 8x8 random stream against a window model.
module tb_ifm_window_gen;
   import cnn_pkg::*;

   typedef struct {
      int   trig_pix;
      win_t exp_win;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ifm_window_gen_if if5();
   ifm_window_gen_if if8();

   ifm_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));
   ifm_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   pix_t img5 [64];
   pix_t img8 [64];
   vec_t vec [9];
   logic clr5 = 1'b0, clr8 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observed traffic per DUT, sampled on the falling edge.
   win_t got5[$], got8[$];
   int   got_cyc5[$], got_cyc8[$], acc_cyc5[$], acc_cyc8[$];
   int   rl_n5, rl_n8, leak5, leak8, hold_err5, hold_err8, fd5, fd8, fd_cyc5, fd_cyc8;
   logic held5, held8;
   win_t held_win5, held_win8;

   always @(negedge clk) begin
      if (clr5) begin
         got5.delete(); got_cyc5.delete(); acc_cyc5.delete();
         rl_n5 <= 0; leak5 <= 0; hold_err5 <= 0; fd5 <= 0; fd_cyc5 <= 0; held5 <= 1'b0;
      end else if (!rst) begin
         if (if5.pix_valid && if5.pix_ready) acc_cyc5.push_back(cyc);
         if (if5.ready_load) rl_n5 <= rl_n5 + 1;
         if (if5.ready_load && !if5.win_stall) begin
            got5.push_back(if5.ifm_window);
            got_cyc5.push_back(cyc);
         end
         if (if5.ready_load && if5.win_stall && if5.pix_ready) leak5 <= leak5 + 1;
         if (held5 && (!if5.ready_load || if5.ifm_window !== held_win5)) hold_err5 <= hold_err5 + 1;
         held5     <= if5.ready_load && if5.win_stall;
         held_win5 <= if5.ifm_window;
         if (if5.frame_done) begin fd5 <= fd5 + 1; fd_cyc5 <= cyc; end
      end
   end

   always @(negedge clk) begin
      if (clr8) begin
         got8.delete(); got_cyc8.delete(); acc_cyc8.delete();
         rl_n8 <= 0; leak8 <= 0; hold_err8 <= 0; fd8 <= 0; fd_cyc8 <= 0; held8 <= 1'b0;
      end else if (!rst) begin
         if (if8.pix_valid && if8.pix_ready) acc_cyc8.push_back(cyc);
         if (if8.ready_load) rl_n8 <= rl_n8 + 1;
         if (if8.ready_load && !if8.win_stall) begin
            got8.push_back(if8.ifm_window);
            got_cyc8.push_back(cyc);
         end
         if (if8.ready_load && if8.win_stall && if8.pix_ready) leak8 <= leak8 + 1;
         if (held8 && (!if8.ready_load || if8.ifm_window !== held_win8)) hold_err8 <= hold_err8 + 1;
         held8     <= if8.ready_load && if8.win_stall;
         held_win8 <= if8.ifm_window;
         if (if8.frame_done) begin fd8 <= fd8 + 1; fd_cyc8 <= cyc; end
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end else begin
         $display("ok   %s = %0d", nm, act);
      end
   endtask

   task automatic chk_win(input string nm, input win_t act, input win_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end else begin
         $display("ok   %s = %h", nm, act);
      end
   endtask

   function automatic win_t mk9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
      int   a [9];
      win_t w;
      a = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
      for (int i = 0; i < 9; i++) w[i] = pix_t'(a[i]);
      return w;
   endfunction

   function automatic pix_t pix_of(input int which, input int k);
      return (which == 5) ? img5[k] : img8[k];
   endfunction
   function automatic logic rl_of(input int which);
      return (which == 5) ? if5.ready_load : if8.ready_load;
   endfunction
   function automatic logic pr_of(input int which);
      return (which == 5) ? if5.pix_ready : if8.pix_ready;
   endfunction
   function automatic int n_got(input int which);
      return (which == 5) ? got5.size() : got8.size();
   endfunction
   function automatic int fd_of(input int which);
      return (which == 5) ? fd5 : fd8;
   endfunction
   function automatic win_t got_of(input int which, input int i);
      return (which == 5) ? got5[i] : got8[i];
   endfunction

   task automatic drv(input int which, input logic fs, input logic pv, input pix_t pd, input logic ws);
      if (which == 5) begin
         if5.frame_start = fs; if5.pix_valid = pv; if5.pix_data = pd; if5.win_stall = ws;
      end else begin
         if8.frame_start = fs; if8.pix_valid = pv; if8.pix_data = pd; if8.win_stall = ws;
      end
   endtask

   // Pulse frame_start, then offer npix pixels with random gaps/stalls; ends #1 after the last accept.
   task automatic run_plane(input int which, input int npix, input int vpct, input int spct,
                            input int stall_idx, input int stall_len, input logic fs_noise);
      int   k = 0, sused = 0, guard = 0;
      logic pv, ws, acc;
      @(posedge clk); #1;
      drv(which, 1'b1, 1'b0, '0, 1'b0);
      if (which == 5) clr5 = 1'b1; else clr8 = 1'b1;
      @(posedge clk); #1;
      clr5 = 1'b0; clr8 = 1'b0;
      while (k < npix && guard < 5000) begin
         pv = ($urandom_range(99) < vpct);
         ws = 1'b0;
         if (rl_of(which)) begin
            if (n_got(which) == stall_idx && sused < stall_len) begin
               ws = 1'b1;
               sused++;
            end else if ($urandom_range(99) < spct) begin
               ws = 1'b1;
            end
         end
         drv(which, fs_noise && ($urandom_range(9) == 0), pv, pix_of(which, k), ws);
         @(negedge clk);
         acc = pv && pr_of(which);
         @(posedge clk); #1;
         if (acc) k++;
         guard++;
      end
      if (guard >= 5000) chk("pixel feed timeout", k, npix);
   endtask

   task automatic drain(input int which, input int spct);
      int   g = 0;
      logic ws;
      while (fd_of(which) == 0 && g < 300) begin
         ws = rl_of(which) && ($urandom_range(99) < spct);
         drv(which, 1'b0, 1'b0, '0, ws);
         @(posedge clk); #1;
         g++;
      end
      drv(which, 1'b0, 1'b0, '0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      chk($sformatf("dut%0d frame_done pulses", which), fd_of(which), 1);
   endtask

   // Reference: every fully-inside KxK window in raster order of its top-left corner.
   task automatic cmp_plane(input int which, input string nm);
      win_t e[$];
      int   w = (which == 5) ? 5 : 8;
      for (int r = 0; r <= w - K; r++) begin
         for (int c = 0; c <= w - K; c++) begin
            win_t x;
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  x[i*K+j] = pix_of(which, (r + i) * w + c + j);
            e.push_back(x);
         end
      end
      chk({nm, " window count"}, n_got(which), e.size());
      for (int i = 0; i < e.size() && i < n_got(which); i++)
         chk_win($sformatf("%s win%0d", nm, i), got_of(which, i), e[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0].trig_pix = 12; vec[0].exp_win = mk9( 0,  1,  2,  5,  6,  7, 10, 11, 12);
      vec[1].trig_pix = 13; vec[1].exp_win = mk9( 1,  2,  3,  6,  7,  8, 11, 12, 13);
      vec[2].trig_pix = 14; vec[2].exp_win = mk9( 2,  3,  4,  7,  8,  9, 12, 13, 14);
      vec[3].trig_pix = 17; vec[3].exp_win = mk9( 5,  6,  7, 10, 11, 12, 15, 16, 17);
      vec[4].trig_pix = 18; vec[4].exp_win = mk9( 6,  7,  8, 11, 12, 13, 16, 17, 18);
      vec[5].trig_pix = 19; vec[5].exp_win = mk9( 7,  8,  9, 12, 13, 14, 17, 18, 19);
      vec[6].trig_pix = 22; vec[6].exp_win = mk9(10, 11, 12, 15, 16, 17, 20, 21, 22);
      vec[7].trig_pix = 23; vec[7].exp_win = mk9(11, 12, 13, 16, 17, 18, 21, 22, 23);
      vec[8].trig_pix = 24; vec[8].exp_win = mk9(12, 13, 14, 17, 18, 19, 22, 23, 24);

      // Reset, with frame_start held during it: rst must win.
      rst = 1'b1;
      drv(5, 1'b1, 1'b0, '0, 1'b0);
      drv(8, 1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("rst ready_load", if5.ready_load, 0);
      chk("rst pix_ready", if5.pix_ready, 0);
      chk("rst frame_done", if5.frame_done, 0);
      chk_win("rst ifm_window", if5.ifm_window, '0);
      chk("rst dut8 ready_load", if8.ready_load, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      drv(5, 1'b0, 1'b1, '0, 1'b0);
      drv(8, 1'b0, 1'b0, '0, 1'b0);
      @(negedge clk); @(negedge clk);
      chk("idle ignores pixels", if5.pix_ready, 0);
      drv(5, 1'b0, 1'b0, '0, 1'b0);

      // Ramp plane, no stall: table contents, latency and row-wrap gaps.
      for (int k = 0; k < 25; k++) img5[k] = pix_t'(k);
      run_plane(5, 25, 100, 0, -1, 0, 1'b0);
      drain(5, 0);
      chk("t1 window count", got5.size(), 9);
      for (int i = 0; i < 9 && i < got5.size(); i++) begin
         chk_win($sformatf("t1 win%0d", i), got5[i], vec[i].exp_win);
         chk($sformatf("t1 win%0d cycle", i), got_cyc5[i], acc_cyc5[vec[i].trig_pix] + 1);
      end
      chk("t1 ready_load cycles", rl_n5, 9);
      if (got5.size() == 9) chk("t1 frame_done cycle", fd_cyc5, got_cyc5[8] + 1);

      // Same plane, second window stalled 4 cycles.
      run_plane(5, 25, 100, 0, 1, 4, 1'b0);
      drain(5, 0);
      chk("t2 window count", got5.size(), 9);
      for (int i = 0; i < 9 && i < got5.size(); i++)
         chk_win($sformatf("t2 win%0d", i), got5[i], vec[i].exp_win);
      chk("t2 ready_load cycles", rl_n5, 13);
      if (got5.size() >= 2) chk("t2 win1 hold span", got_cyc5[1] - got_cyc5[0], 5);
      chk("t2 hold violations", hold_err5, 0);
      chk("t2 accepts while stalled", leak5, 0);

      // Reset right after pixel 13, then a fresh random plane.
      run_plane(5, 14, 100, 0, -1, 0, 1'b0);
      rst = 1'b1;
      drv(5, 1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("t5 ready_load after rst", if5.ready_load, 0);
      chk("t5 windows before rst", got5.size(), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      drv(5, 1'b0, 1'b1, '0, 1'b0);
      repeat (3) @(negedge clk);
      chk("t5 idle after abort", if5.pix_ready, 0);
      for (int k = 0; k < 25; k++) img5[k] = pix_t'($urandom);
      run_plane(5, 25, 100, 0, -1, 0, 1'b0);
      drain(5, 0);
      cmp_plane(5, "t5");

      // Signed extremes with gaps and stalls.
      for (int k = 0; k < 25; k++) begin
         case ($urandom_range(3))
            0: img5[k] = -8'sd128;
            1: img5[k] = 8'sd127;
            2: img5[k] = -8'sd1;
            default: img5[k] = pix_t'($urandom);
         endcase
      end
      run_plane(5, 25, 70, 30, -1, 0, 1'b0);
      drain(5, 30);
      cmp_plane(5, "t6");
      chk("t6 hold violations", hold_err5, 0);
`ifdef IFM_WIN_CNT_EN
      chk("t6 win_count", if5.win_count, 9);
`endif

      // 8x8 random gaps, stalls and stray frame_start pulses.
      for (int k = 0; k < 64; k++) img8[k] = pix_t'($urandom);
      run_plane(8, 64, 50, 25, -1, 0, 1'b1);
      drain(8, 25);
      cmp_plane(8, "t4");
      chk("t4 hold violations", hold_err8, 0);
      chk("t4 accepts while stalled", leak8, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
